render_port_arbiter: RTL
========================

Name: render_port_arbiter

Overview:
Multi-engine successor to the single-engine DDR port-0 write path. It merges point data from NUM_ENGINES Mandelbrot rendering engines onto one MCB write port. Arbitration is round-robin, one burst per grant. Each engine owns a contiguous region of the frame. The block rotates over NUM_FRAMES frame buffers and reports the last completed frame to the display-side port controller.

Parameters:
NUM_ENGINES, 4, number of render-engine channels (1..8)
BURST_LEN, 16, maximum words per MCB write command (1..64)
REGION_WORDS, 230400, 32-bit words per engine region; must be a multiple of BURST_LEN
NUM_FRAMES, 2, number of frame buffers in DDR (2..4)
FRAME_BYTES, 3686400, byte stride between frame base addresses

Ports:
clk  in  1  render clock; all logic on its rising edge
SYS_RESETn  in  1  asynchronous active-low reset
mem_calib_done  in  1  MCB calibration complete
eng_ready  in  NUM_ENGINES  per-engine: eng_data word valid
eng_data  in  32*NUM_ENGINES  per-engine point word; channel c occupies bits [32c+31:32c]
eng_send  out  NUM_ENGINES  per-engine one-cycle accept strobe
eng_clear  out  1  one-cycle pulse: all engines restart a new frame
p0_wr_full  in  1  MCB write FIFO full
p0_wr_empty  in  1  MCB write FIFO empty
p0_wr_en  out  1  write-FIFO push
p0_wr_data  out  32  write-FIFO data
p0_wr_mask  out  4  always 4'b0000
p0_cmd_en  out  1  command strobe
p0_cmd_instr  out  3  always 3'b000 (write)
p0_cmd_bl  out  6  burst length minus 1
p0_cmd_byte_addr  out  30  burst start byte address
display_frame  out  2  index of the last fully written frame
stall_count  out  32  FIFO-full stall cycles (see Optional Feature)

Behaviour:
- Reset values: all outputs 0; display_frame = NUM_FRAMES-1; write frame index wf = 0; all channel pointers 0; round-robin pointer 0.
- State machine: WAIT_CAL -> ARB -> XFER -> CMD -> ARB; ARB -> SWAP -> ARB.
- WAIT_CAL: hold until mem_calib_done = 1, then go to ARB.
- ARB: if every channel's done flag is set, go to SWAP. Otherwise grant the first channel at or after the rr pointer with eng_ready = 1 and done clear. Latch its pointer as the burst start, clear the burst count, go to XFER. If no channel qualifies, stay in ARB.
- XFER: eng_send[g] = eng_ready[g] & ~p0_wr_full, combinational. On each accept:
  - p0_wr_en = 1 and p0_wr_data = eng_data[g] in the same cycle;
  - burst count and channel pointer increment.
- XFER exits to CMD on any of:
  - burst count reaches BURST_LEN;
  - eng_ready[g] low with count > 0 for 16 consecutive cycles (partial flush);
  - channel pointer reaches REGION_WORDS; the channel's done flag is set.
- XFER with count = 0 and eng_ready[g] low returns to ARB without issuing a command.
- CMD: single-cycle p0_cmd_en pulse.
  - p0_cmd_bl = count-1.
  - p0_cmd_byte_addr = wf*FRAME_BYTES + (g*REGION_WORDS + start)*4, truncated to 30 bits.
  - rr pointer becomes g+1 mod NUM_ENGINES.
- p0_wr_full stalls acceptance only; the word is never dropped and eng_send stays 0 while full.
- SWAP: wait for p0_wr_empty = 1. Then, in one cycle:
  - display_frame <= wf;
  - wf <= (wf+1) mod NUM_FRAMES;
  - pulse eng_clear;
  - clear all done flags and pointers.
- Engines that are ready but already done are never granted until SWAP completes.
- Reset asserted mid-burst aborts immediately. The partial FIFO contents are not commanded; the MCB side is reset by the system.
- At most one eng_send bit is high in any cycle. p0_cmd_en and p0_wr_en are never high in the same cycle.

Optional Feature:
- Macro ARB_STALL_COUNT_EN.
- Defined: stall_count increments in every XFER cycle with p0_wr_full = 1 and eng_ready[g] = 1. It saturates at 32'hFFFFFFFF and clears on reset and on each SWAP.
- Undefined: stall_count is constant 0 and no counter logic is built.

Test Plan:
(Parameters for all scenarios: NUM_ENGINES=2, BURST_LEN=4, REGION_WORDS=8, NUM_FRAMES=2, FRAME_BYTES=64.)
- Calibration gating: mem_calib_done=0 with both engines ready for 50 cycles -> no eng_send, p0_wr_en or p0_cmd_en. Raise calib -> first grant goes to engine 0.
- Round-robin: both engines stream continuously -> commands alternate at addresses 0x00 (ch0), 0x20 (ch1), 0x10 (ch0), 0x30 (ch1), each with bl=3.
- Back-pressure: hold p0_wr_full=1 for 10 cycles mid-burst -> eng_send=0 throughout, word sequence intact, 4 words still pushed before the cmd. With ARB_STALL_COUNT_EN, stall_count=10.
- Partial flush: engine 0 supplies 2 words then drops ready for 16 cycles -> cmd with bl=1, addr 0x00. Next ch0 burst starts at addr 0x08.
- Frame swap: both regions complete, p0_wr_empty raised 5 cycles later -> eng_clear pulses once, display_frame=0, next ch0 cmd addr 0x40. After the second frame, display_frame=1 and the next ch0 cmd addr is 0x00.
- Async reset: drop SYS_RESETn mid-XFER -> all outputs 0 with no clock edge, display_frame=1. Restart begins at ch0, addr 0x00.

Source files
------------

// File: rtl/render_port_arbiter.sv
// render_port_arbiter: round-robin merge of render engines onto MCB port 0.
// Build option ARB_STALL_COUNT_EN adds the FIFO-full stall counter.
module render_port_arbiter #(
  parameter int NUM_ENGINES  = 4,
  parameter int BURST_LEN    = 16,
  parameter int REGION_WORDS = 230400,
  parameter int NUM_FRAMES   = 2,
  parameter int FRAME_BYTES  = 3686400
) (
  input  logic                     clk,
  input  logic                     SYS_RESETn,
  input  logic                     mem_calib_done,
  input  logic [NUM_ENGINES-1:0]   eng_ready,
  input  logic [32*NUM_ENGINES-1:0] eng_data,
  output logic [NUM_ENGINES-1:0]   eng_send,
  output logic                     eng_clear,
  input  logic                     p0_wr_full,
  input  logic                     p0_wr_empty,
  output logic                     p0_wr_en,
  output logic [31:0]              p0_wr_data,
  output logic [3:0]               p0_wr_mask,
  output logic                     p0_cmd_en,
  output logic [2:0]               p0_cmd_instr,
  output logic [5:0]               p0_cmd_bl,
  output logic [29:0]              p0_cmd_byte_addr,
  output logic [1:0]               display_frame,
  output logic [31:0]              stall_count
);

  localparam int GW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam int PW = $clog2(REGION_WORDS + 1);
  localparam int CW = $clog2(BURST_LEN + 1);

  typedef enum logic [2:0] {
    S_WAIT_CAL,
    S_ARB,
    S_XFER,
    S_CMD,
    S_SWAP
  } state_t;

  state_t state;
  state_t state_nx;

  logic [GW-1:0]          rr;
  logic [GW-1:0]          g;
  logic [GW-1:0]          pick;
  logic [GW-1:0]          cand;
  logic                   pick_ok;
  logic [NUM_ENGINES-1:0] done;
  logic [PW-1:0]          ptr [NUM_ENGINES];
  logic [PW-1:0]          ptr_g;
  logic [PW-1:0]          start;
  logic [CW-1:0]          cnt;
  logic [3:0]             idle;
  logic [1:0]             wf;
  logic [1:0]             df;
  logic [31:0]            g_data;
  logic [29:0]            cmd_addr;
  logic                   all_done;
  logic                   g_ready;
  logic                   accept;
  logic                   last_word;
  logic                   burst_full;
  logic                   xfer_cmd;
  logic                   xfer_quit;
  logic                   swap_go;

  assign all_done   = &done;
  assign g_ready    = eng_ready[g];
  assign ptr_g      = ptr[g];
  assign accept     = (state == S_XFER) && g_ready && !p0_wr_full;
  assign last_word  = (ptr_g == PW'(REGION_WORDS - 1));
  assign burst_full = (cnt == CW'(BURST_LEN - 1));
  assign swap_go    = (state == S_SWAP) && p0_wr_empty;

  // Flush a partial burst once the engine has been idle for 16 cycles.
  assign xfer_cmd  = (accept && (burst_full || last_word))
                   || (!g_ready && (cnt != '0) && (idle == 4'd15));
  assign xfer_quit = !g_ready && (cnt == '0);

  assign cmd_addr = 30'(wf) * 30'(FRAME_BYTES)
                  + (30'(g) * 30'(REGION_WORDS) + 30'(start)) * 30'd4;

  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    cand    = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      if (int'(rr) + i >= NUM_ENGINES) begin
        cand = GW'(int'(rr) + i - NUM_ENGINES);
      end else begin
        cand = GW'(int'(rr) + i);
      end
      if (!pick_ok && eng_ready[cand] && !done[cand]) begin
        pick    = cand;
        pick_ok = 1'b1;
      end
    end
  end

  always_comb begin
    g_data = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      if (GW'(i) == g) begin
        g_data = eng_data[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge SYS_RESETn) begin
    if (!SYS_RESETn) begin
      state <= S_WAIT_CAL;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_WAIT_CAL: begin
        if (mem_calib_done) state_nx = S_ARB;
      end
      S_ARB: begin
        if (all_done) state_nx = S_SWAP;
        else if (pick_ok) state_nx = S_XFER;
      end
      S_XFER: begin
        unique case (1'b1)
          xfer_cmd:  state_nx = S_CMD;
          xfer_quit: state_nx = S_ARB;
          default:   state_nx = S_XFER;
        endcase
      end
      S_CMD: begin
        state_nx = S_ARB;
      end
      S_SWAP: begin
        if (p0_wr_empty) state_nx = S_ARB;
      end
      default: begin
        state_nx = S_WAIT_CAL;
      end
    endcase
  end

  always_comb begin
    eng_send         = '0;
    eng_clear        = 1'b0;
    p0_wr_en         = 1'b0;
    p0_wr_data       = '0;
    p0_cmd_en        = 1'b0;
    p0_cmd_bl        = '0;
    p0_cmd_byte_addr = '0;
    unique case (state)
      S_XFER: begin
        eng_send[g] = accept;
        p0_wr_en    = accept;
        if (accept) p0_wr_data = g_data;
      end
      S_CMD: begin
        p0_cmd_en        = 1'b1;
        p0_cmd_bl        = 6'(cnt - CW'(1));
        p0_cmd_byte_addr = cmd_addr;
      end
      S_SWAP: begin
        eng_clear = p0_wr_empty;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge SYS_RESETn) begin
    if (!SYS_RESETn) begin
      rr    <= '0;
      g     <= '0;
      start <= '0;
      cnt   <= '0;
      idle  <= '0;
      done  <= '0;
      wf    <= '0;
      df    <= 2'(NUM_FRAMES - 1);
      for (int i = 0; i < NUM_ENGINES; i++) begin
        ptr[i] <= '0;
      end
    end else begin
      unique case (state)
        S_ARB: begin
          if (!all_done && pick_ok) begin
            g     <= pick;
            start <= ptr[pick];
            cnt   <= '0;
            idle  <= '0;
          end
        end
        S_XFER: begin
          if (accept) begin
            cnt    <= cnt + CW'(1);
            ptr[g] <= ptr_g + PW'(1);
            idle   <= '0;
            if (last_word) done[g] <= 1'b1;
          end else if (!g_ready) begin
            idle <= idle + 4'd1;
          end else begin
            idle <= '0;
          end
        end
        S_CMD: begin
          rr <= (g == GW'(NUM_ENGINES - 1)) ? '0 : g + GW'(1);
        end
        S_SWAP: begin
          if (p0_wr_empty) begin
            df   <= wf;
            wf   <= (wf == 2'(NUM_FRAMES - 1)) ? 2'd0 : wf + 2'd1;
            done <= '0;
            for (int i = 0; i < NUM_ENGINES; i++) begin
              ptr[i] <= '0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef ARB_STALL_COUNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge SYS_RESETn) begin
    if (!SYS_RESETn) begin
      stall_q <= '0;
    end else if (swap_go) begin
      stall_q <= '0;
    end else if ((state == S_XFER) && p0_wr_full && g_ready
                 && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

  assign p0_wr_mask    = 4'b0000;
  assign p0_cmd_instr  = 3'b000;
  assign display_frame = df;

  a_send_onehot: assert property (
    @(posedge clk) disable iff (!SYS_RESETn) $onehot0(eng_send));
  a_cmd_wr_excl: assert property (
    @(posedge clk) disable iff (!SYS_RESETn) !(p0_cmd_en && p0_wr_en));

endmodule
